// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem read in flight,
// and loads the IF/ID pipeline register under hazard-unit and redirect control.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_enable,
  input  logic        ifid_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FULL,
    S_DROP
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_instr;
  logic [1:0]  settle_cnt;
  logic        deliver;
  logic [31:0] deliver_instr;

  // A response to a fetch issued before reset may still arrive just after it;
  // holding off the first request for two cycles keeps it from being mistaken
  // for the answer to a fresh request.
  assign imem_req  = (state == S_REQ) & pc_enable & ~redirect_valid & ~rst &
                     (settle_cnt == 2'd0);
  assign imem_addr = pc;

  always_comb begin
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    if (!redirect_valid && ifid_enable) begin
      if (state == S_WAIT && imem_rvalid) begin
        deliver = 1'b1;
      end else if (state == S_FULL) begin
        deliver       = 1'b1;
        deliver_instr = hold_instr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      hold_instr <= 32'h0000_0000;
      settle_cnt <= 2'd2;
      ifid_valid <= 1'b0;
      ifid_pc    <= 32'h0000_0000;
      ifid_instr <= NOP;
    end else begin
      if (settle_cnt != 2'd0) begin
        settle_cnt <= settle_cnt - 2'd1;
      end

      if (redirect_valid) begin
        pc         <= {redirect_pc[31:2], 2'b00};
        ifid_valid <= 1'b0;
        // An outstanding request still owes a response; wait it out in S_DROP.
        if ((state == S_WAIT || state == S_DROP) && !imem_rvalid) begin
          state <= S_DROP;
        end else begin
          state <= S_REQ;
        end
      end else begin
        if (ifid_enable) begin
          ifid_valid <= deliver;
          if (deliver) begin
            ifid_pc    <= pc;
            ifid_instr <= deliver_instr;
            pc         <= pc + 32'd4;
          end
        end

        case (state)
          S_REQ: begin
            if (imem_req) begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (ifid_enable) begin
                state <= S_REQ;
              end else begin
                hold_instr <= imem_rdata;
                state      <= S_FULL;
              end
            end
          end
          S_FULL: begin
            if (ifid_enable) begin
              state <= S_REQ;
            end
          end
          S_DROP: begin
            if (imem_rvalid) begin
              state <= S_REQ;
            end
          end
          default: state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scenario tasks drive the memory side and
// hazard/redirect inputs; a monitor pops expected IF/ID contents on each delivery.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        pc_enable;
  logic        ifid_enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] last_pc;
  logic [31:0] last_instr;
  logic        mon_take;
  exp_t        mon_e;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_enable      (pc_enable),
    .ifid_enable    (ifid_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard side: a delivery is any edge with IF/ID enabled that leaves it valid.
  always @(posedge clk) begin
    mon_take = ifid_enable && !redirect_valid && !rst;
    #1;
    if (mon_take && ifid_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_delivery: got pc=%h instr=%h, required no delivery",
                 ifid_pc, ifid_instr);
      end else begin
        mon_e = exp_q.pop_front();
        if (ifid_pc !== mon_e.pc || ifid_instr !== mon_e.instr) begin
          n_fail++;
          $display("[TB] FAIL delivery: got pc=%h instr=%h, required pc=%h instr=%h",
                   ifid_pc, ifid_instr, mon_e.pc, mon_e.instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completes a fetch whose request is being issued in the current cycle.
  task automatic run_fetch(input logic [31:0] data, input int lat);
    exp_t e;
    e.pc    = model_pc;
    e.instr = data;
    exp_q.push_back(e);
    for (int w = 1; w < lat; w++) tick();
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    #1;
    last_pc    = model_pc;
    last_instr = data;
    model_pc   = model_pc + 32'd4;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_enable = 1'b1; ifid_enable = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    tick(); tick(); #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_req: got %b, required 0", imem_req);
    end
    n_checks++;
    if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== NOP) begin
      n_fail++;
      $display("[TB] FAIL reset_ifid: got v=%b pc=%h instr=%h, required v=0 pc=0 instr=%h",
               ifid_valid, ifid_pc, ifid_instr, NOP);
    end
    rst = 1'b0; #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (imem_req !== 1'b0) begin
        n_fail++; $display("[TB] FAIL reset_settle%0d: got req=%b, required 0", k, imem_req);
      end
      tick();
    end
    model_pc = RESET_PC; last_pc = 32'h0; last_instr = NOP;
  endtask

  task automatic test_basic();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("[TB] FAIL basic_first_req: got req=%b addr=%h, required 1 00000000",
                         imem_req, imem_addr);
    end
    run_fetch(32'h00A0_0093, 1);
    n_checks++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_instr !== 32'h00A0_0093) begin
      n_fail++; $display("[TB] FAIL basic_ifid: got v=%b pc=%h instr=%h, required 1 0 00a00093",
                         ifid_valid, ifid_pc, ifid_instr);
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      n_fail++; $display("[TB] FAIL basic_next_addr: got req=%b addr=%h, required 1 00000004",
                         imem_req, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] data;
    for (int i = 0; i < 4; i++) begin
      int lat;
      lat  = (i % 2) + 1;
      data = $urandom;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
        n_fail++; $display("[TB] FAIL b2b_req%0d: got req=%b addr=%h, required 1 %h",
                           i, imem_req, imem_addr, model_pc);
      end
      e.pc = model_pc; e.instr = data;
      exp_q.push_back(e);
      for (int w = 0; w < lat; w++) begin
        tick();
        if (w == lat - 1) begin
          imem_rvalid = 1'b1; imem_rdata = data;
        end
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || ifid_valid !== 1'b0) begin
          n_fail++; $display("[TB] FAIL b2b_wait%0d: got req=%b valid=%b, required 0 0",
                             i, imem_req, ifid_valid);
        end
      end
      tick();
      imem_rvalid = 1'b0; #1;
      last_pc = model_pc; last_instr = data; model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic test_freeze();
    exp_t e;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0113; ifid_enable = 1'b0;
    e.pc = model_pc; e.instr = 32'h0010_0113;
    exp_q.push_back(e);
    tick();
    imem_rvalid = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ifid_valid !== 1'b0 || ifid_pc !== last_pc || ifid_instr !== last_instr ||
          imem_req !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL freeze_hold%0d: got v=%b pc=%h instr=%h req=%b, required 0 %h %h 0",
                 k, ifid_valid, ifid_pc, ifid_instr, imem_req, last_pc, last_instr);
      end
      if (k < 2) tick();
    end
    ifid_enable = 1'b1;
    tick();
    n_checks++;
    if (ifid_valid !== 1'b1 || ifid_pc !== model_pc || ifid_instr !== 32'h0010_0113) begin
      n_fail++; $display("[TB] FAIL freeze_release: got v=%b pc=%h instr=%h, required 1 %h 00100113",
                         ifid_valid, ifid_pc, ifid_instr, model_pc);
    end
    last_pc = model_pc; last_instr = 32'h0010_0113; model_pc = model_pc + 32'd4;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
      n_fail++; $display("[TB] FAIL freeze_next_req: got req=%b addr=%h, required 1 %h",
                         imem_req, imem_addr, model_pc);
    end
  endtask

  task automatic test_pc_enable();
    pc_enable = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (imem_req !== 1'b0 || (k > 0 && ifid_valid !== 1'b0)) begin
        n_fail++; $display("[TB] FAIL pc_stall%0d: got req=%b valid=%b, required req=0 valid=0",
                           k, imem_req, ifid_valid);
      end
      tick();
    end
    pc_enable = 1'b1; #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
      n_fail++; $display("[TB] FAIL pc_resume: got req=%b addr=%h, required 1 %h",
                         imem_req, imem_addr, model_pc);
    end
    run_fetch(32'h0020_0193, 1);
  endtask

  task automatic test_redirect_req();
    ifid_enable = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("[TB] FAIL redir_req_noissue: got req=%b, required 0", imem_req);
    end
    tick();
    redirect_valid = 1'b0; ifid_enable = 1'b1; #1;
    n_checks++;
    if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
      n_fail++; $display("[TB] FAIL redir_req_flush: got v=%b req=%b addr=%h, required 0 1 00000200",
                         ifid_valid, imem_req, imem_addr);
    end
    model_pc = 32'h0000_0200;
    run_fetch(32'h0030_0213, 1);
  endtask

  task automatic test_redirect_wait();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("[TB] FAIL redir_wait_noissue: got req=%b, required 0", imem_req);
    end
    tick();
    redirect_valid = 1'b0; #1;
    n_checks++;
    if (ifid_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("[TB] FAIL redir_wait_drop: got v=%b req=%b, required 0 0",
                         ifid_valid, imem_req);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0; #1;
    n_checks++;
    if (ifid_valid !== 1'b0 || ifid_instr !== last_instr || imem_req !== 1'b1 ||
        imem_addr !== 32'h0000_0100) begin
      n_fail++; $display("[TB] FAIL redir_wait_new: got v=%b instr=%h req=%b addr=%h, required 0 %h 1 00000100",
                         ifid_valid, ifid_instr, imem_req, imem_addr, last_instr);
    end
    model_pc = 32'h0000_0100;
    run_fetch(32'h0040_0293, 2);
  endtask

  task automatic test_redirect_rvalid();
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hBADC_0DE5;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0302; #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("[TB] FAIL redir_rv_noissue: got req=%b, required 0", imem_req);
    end
    tick();
    imem_rvalid = 1'b0; redirect_valid = 1'b0; #1;
    n_checks++;
    if (ifid_valid !== 1'b0 || ifid_instr !== last_instr || imem_req !== 1'b1 ||
        imem_addr !== 32'h0000_0300) begin
      n_fail++; $display("[TB] FAIL redir_rv_new: got v=%b instr=%h req=%b addr=%h, required 0 %h 1 00000300",
                         ifid_valid, ifid_instr, imem_req, imem_addr, last_instr);
    end
    model_pc = 32'h0000_0300;
    run_fetch(32'h0050_0313, 1);
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0; #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("[TB] FAIL wrap_top: got req=%b addr=%h, required 1 fffffffc",
                         imem_req, imem_addr);
    end
    model_pc = 32'hFFFF_FFFC;
    run_fetch(32'h0060_0393, 1);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
      n_fail++; $display("[TB] FAIL wrap_next: got req=%b addr=%h, required 1 00000000",
                         imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_midfetch();
    tick();
    rst = 1'b1; #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_mid_req: got req=%b, required 0", imem_req);
    end
    tick();
    rst = 1'b0; #1;
    n_checks++;
    if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== NOP || imem_req !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_mid_clear: got v=%b pc=%h instr=%h req=%b, required 0 0 %h 0",
                         ifid_valid, ifid_pc, ifid_instr, imem_req, NOP);
    end
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hFEED_F00D; #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_mid_settle: got req=%b, required 0", imem_req);
    end
    tick();
    imem_rvalid = 1'b0; #1;
    n_checks++;
    if (ifid_valid !== 1'b0 || ifid_instr !== NOP || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++; $display("[TB] FAIL rst_mid_first: got v=%b instr=%h req=%b addr=%h, required 0 %h 1 %h",
                         ifid_valid, ifid_instr, imem_req, imem_addr, NOP, RESET_PC);
    end
    model_pc = RESET_PC; last_pc = 32'h0; last_instr = NOP;
    run_fetch(32'h0070_0413, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_freeze();
    test_pc_enable();
    test_redirect_req();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_reset_midfetch();
    tick(); tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("[TB] FAIL scoreboard_drain: got %0d undelivered, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
